// File: rtl/vm_dispense_ctrl.sv
// vm_dispense_ctrl: vending dispense and change-payout controller.
// Define VM_STOCK_TRACK_EN to add per-item stock counters, restock and the sold-out check.
module vm_dispense_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_item,
    input  logic [1:0] req_amt,
    input  logic [5:0] req_change,
    output logic       req_ready,
    output logic       vend_req,
    output logic [2:0] vend_item,
    input  logic       vend_ack,
    output logic [2:0] coin_out,
    input  logic       coin_ack,
    output logic       fin_valid,
    output logic [1:0] fin_status,
    output logic       busy,
    output logic [4:0] sold_out,
    input  logic       restock,
    input  logic [2:0] restock_item
);
    typedef enum logic [2:0] {IDLE, CHECK, VEND, PAY, FIN} state_t;
    state_t     state_q;
    logic [2:0] item_q;
    logic [1:0] amt_q;
    logic [5:0] chg_q, chg_d;
    logic       req_ready_q, busy_q, vend_req_q, fin_valid_q;
    logic [2:0] vend_item_q, coin_out_q;
    logic [1:0] fin_status_q, chk_st;
    logic       item_ok, stk_short;

    function automatic logic [2:0] coin_sel(input logic [5:0] c);
        return (c >= 6'd25) ? 3'b100 : (c >= 6'd10) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [5:0] coin_val(input logic [2:0] o);
        return o[2] ? 6'd25 : o[1] ? 6'd10 : 6'd5;
    endfunction

    assign item_ok = (item_q >= 3'd1) && (item_q <= 3'd5);
    // coin_out_q always matches coin_sel(chg_q) in PAY, so this never underflows
    assign chg_d   = chg_q - coin_val(coin_out_q);
    assign chk_st  = (!item_ok || amt_q == 2'd0) ? 2'b01 :
                     stk_short                   ? 2'b10 :
                     (chg_q % 6'd5 != 6'd0)      ? 2'b11 : 2'b00;

`ifdef VM_STOCK_TRACK_EN
    logic [3:0] stock_q [5];
    logic [3:0] stk;
    logic       dec;
    assign dec = (state_q == VEND) && vend_ack;
    always_comb begin
        stk = 4'd0;
        for (int i = 0; i < 5; i++) if (item_q == 3'(i + 1)) stk = stock_q[i];
    end
    assign stk_short = stk < {2'b00, amt_q};
    // restock has priority over a same-cycle decrement of the same item
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) stock_q[i] <= 4'd9;
        end else begin
            for (int i = 0; i < 5; i++)
                if (restock && restock_item == 3'(i + 1)) stock_q[i] <= 4'd15;
                else if (dec && item_q == 3'(i + 1)) stock_q[i] <= stock_q[i] - 4'd1;
        end
    end
    always_comb begin
        sold_out = 5'b0;
        for (int i = 0; i < 5; i++) sold_out[i] = stock_q[i] == 4'd0;
    end
`else
    logic unused_restock;
    assign unused_restock = ^{restock, restock_item};
    assign stk_short      = 1'b0;
    assign sold_out       = 5'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            item_q       <= 3'd0;
            amt_q        <= 2'd0;
            chg_q        <= 6'd0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            vend_req_q   <= 1'b0;
            vend_item_q  <= 3'd0;
            coin_out_q   <= 3'b000;
            fin_valid_q  <= 1'b0;
            fin_status_q <= 2'b00;
        end else begin
            fin_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    item_q      <= req_item;
                    amt_q       <= req_amt;
                    chg_q       <= req_change;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= CHECK;
                end
                CHECK: if (chk_st != 2'b00) begin
                    fin_status_q <= chk_st;
                    fin_valid_q  <= 1'b1;
                    state_q      <= FIN;
                end else begin
                    vend_req_q  <= 1'b1;
                    vend_item_q <= item_q;
                    state_q     <= VEND;
                end
                VEND: if (vend_ack) begin
                    amt_q <= amt_q - 2'd1;
                    if (amt_q == 2'd1) begin
                        vend_req_q <= 1'b0;
                        if (chg_q != 6'd0) begin
                            coin_out_q <= coin_sel(chg_q);
                            state_q    <= PAY;
                        end else begin
                            fin_status_q <= 2'b00;
                            fin_valid_q  <= 1'b1;
                            state_q      <= FIN;
                        end
                    end
                end
                PAY: if (coin_ack) begin
                    chg_q <= chg_d;
                    if (chg_d == 6'd0) begin
                        coin_out_q   <= 3'b000;
                        fin_status_q <= 2'b00;
                        fin_valid_q  <= 1'b1;
                        state_q      <= FIN;
                    end else begin
                        coin_out_q <= coin_sel(chg_d);
                    end
                end
                FIN: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign vend_req   = vend_req_q;
    assign vend_item  = vend_item_q;
    assign coin_out   = coin_out_q;
    assign fin_valid  = fin_valid_q;
    assign fin_status = fin_status_q;
endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// tb_vm_dispense_ctrl: directed bench for vm_dispense_ctrl with a step-queue reference model.
module tb_vm_dispense_ctrl;
`ifdef VM_STOCK_TRACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    logic       clk = 1'b0, rst;
    logic       req_valid, req_ready, vend_req, vend_ack, coin_ack, fin_valid, busy, restock;
    logic [2:0] req_item, vend_item, coin_out, restock_item;
    logic [1:0] req_amt, fin_status;
    logic [5:0] req_change;
    logic [4:0] sold_out;
    logic       vack_auto, vack_m, cack_auto, cack_m;

    assign vend_ack = vack_auto ? vend_req : vack_m;
    assign coin_ack = cack_auto ? |coin_out : cack_m;

    always #5 clk = ~clk;

    vm_dispense_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_item(req_item), .req_amt(req_amt),
        .req_change(req_change), .req_ready(req_ready), .vend_req(vend_req), .vend_item(vend_item),
        .vend_ack(vend_ack), .coin_out(coin_out), .coin_ack(coin_ack), .fin_valid(fin_valid),
        .fin_status(fin_status), .busy(busy), .sold_out(sold_out), .restock(restock),
        .restock_item(restock_item)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    // Model: each request becomes a queue of steps (0 check, 1 vend unit, 2 coin, 3 finish)
    typedef struct packed { logic [1:0] k; logic [2:0] v; } step_t;
    step_t      q[$];
    logic [2:0] m_item;
    logic [1:0] m_amt, m_last;
    logic [5:0] m_chg;
    int         stock[5];
    int         cyc_n = 0, acc_cyc = 0, fin_cyc = 0, fin_cnt = 0, vack_cnt = 0, f0 = 0;
    logic [2:0] coins_seen[$];

    function automatic step_t mk(input logic [1:0] k, input logic [2:0] v);
        step_t t;
        t.k = k;
        t.v = v;
        return t;
    endfunction

    always @(negedge clk) begin : cmp
        step_t s;
        logic  emp;
        logic  [4:0] so;
        int    st, r;
        cyc_n++;
        if (rst) begin
            q.delete();
            m_last = 2'b00;
            for (int i = 0; i < 5; i++) stock[i] = 9;
        end else begin
            emp = q.size() == 0;
            s = emp ? mk(2'd0, 3'd0) : q[0];
            for (int i = 0; i < 5; i++) so[i] = STK && stock[i] == 0;
            chk("req_ready", 8'(req_ready), 8'(emp));
            chk("busy", 8'(busy), 8'(!emp));
            chk("vend_req", 8'(vend_req), 8'(!emp && s.k == 2'd1));
            chk("coin_out", 8'(coin_out), (!emp && s.k == 2'd2) ? 8'(s.v) : 8'd0);
            chk("fin_valid", 8'(fin_valid), 8'(!emp && s.k == 2'd3));
            chk("fin_status", 8'(fin_status), (!emp && s.k == 2'd3) ? 8'(s.v[1:0]) : 8'(m_last));
            chk("sold_out", 8'(sold_out), 8'(so));
            if (!emp && s.k == 2'd1) chk("vend_item", 8'(vend_item), 8'(m_item));
            if (emp) begin
                if (req_valid) begin
                    m_item = req_item; m_amt = req_amt; m_chg = req_change;
                    q.push_back(mk(2'd0, 3'd0));
                    acc_cyc = cyc_n;
                end
            end else begin
                case (s.k)
                    2'd0: begin
                        void'(q.pop_front());
                        st = (m_chg % 5 != 0) ? 3 : 0;
                        if (STK && m_item >= 1 && m_item <= 5 && stock[m_item - 1] < int'(m_amt)) st = 2;
                        if (m_item < 1 || m_item > 5 || m_amt == 0) st = 1;
                        if (st != 0) q.push_back(mk(2'd3, 3'(st)));
                        else begin
                            for (int i = 0; i < int'(m_amt); i++) q.push_back(mk(2'd1, 3'd0));
                            r = int'(m_chg);
                            while (r > 0) begin
                                q.push_back(mk(2'd2, r >= 25 ? 3'b100 : r >= 10 ? 3'b010 : 3'b001));
                                r -= r >= 25 ? 25 : r >= 10 ? 10 : 5;
                            end
                            q.push_back(mk(2'd3, 3'd0));
                        end
                    end
                    2'd1: if (vend_ack) begin
                        void'(q.pop_front());
                        vack_cnt++;
                        if (STK) stock[m_item - 1]--;
                    end
                    2'd2: if (coin_ack) begin
                        void'(q.pop_front());
                        coins_seen.push_back(coin_out);
                    end
                    default: begin
                        void'(q.pop_front());
                        m_last = s.v[1:0];
                        fin_cyc = cyc_n;
                        fin_cnt++;
                    end
                endcase
            end
            if (STK && restock && restock_item >= 1 && restock_item <= 5) stock[restock_item - 1] = 15;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] it, input logic [1:0] am, input logic [5:0] ch);
        req_valid = 1'b1; req_item = it; req_amt = am; req_change = ch;
        f0 = fin_cnt;
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_fin();
        for (int i = 0; i < 60 && fin_cnt == f0; i++) cyc(1);
        chk("fin_seen", 8'(fin_cnt - f0), 8'd1);
    endtask

    task automatic wait_coin(input logic [2:0] c);
        for (int i = 0; i < 40 && coin_out != c; i++) cyc(1);
        chk("wait_coin", 8'(coin_out), 8'(c));
    endtask

    task automatic wait_vreq();
        for (int i = 0; i < 40 && !vend_req; i++) cyc(1);
        chk("wait_vreq", 8'(vend_req), 8'd1);
    endtask

    task automatic clr();
        coins_seen.delete();
        vack_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_item = 3'd0; req_amt = 2'd0; req_change = 6'd0;
        restock = 1'b0; restock_item = 3'd0;
        vack_auto = 1'b1; cack_auto = 1'b1; vack_m = 1'b0; cack_m = 1'b0;
        #1;
        chk("rst_ready", 8'(req_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_vreq", 8'(vend_req), 8'd0);
        chk("rst_vitem", 8'(vend_item), 8'd0);
        chk("rst_coin", 8'(coin_out), 8'd0);
        chk("rst_fin", 8'({fin_valid, fin_status}), 8'd0);
        chk("rst_sold", 8'(sold_out), 8'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        cyc(2);

        clr(); send(3'd2, 2'd2, 6'd40); wait_fin();
        chk("s1_lat", 8'(fin_cyc - acc_cyc), 8'd7);
        chk("s1_vacks", 8'(vack_cnt), 8'd2);
        chk("s1_ncoins", 8'(coins_seen.size()), 8'd3);
        if (coins_seen.size() == 3) begin
            chk("s1_coin0", 8'(coins_seen[0]), 8'b100);
            chk("s1_coin1", 8'(coins_seen[1]), 8'b010);
            chk("s1_coin2", 8'(coins_seen[2]), 8'b001);
        end
        chk("s1_status", 8'(fin_status), 8'd0);
        if (STK) chk("s1_stockB", 8'(stock[1]), 8'd7);

        clr(); send(3'd7, 2'd1, 6'd0); wait_fin();
        chk("s2_lat", 8'(fin_cyc - acc_cyc), 8'd2);
        chk("s2_status", 8'(fin_status), 8'd1);
        chk("s2_vacks", 8'(vack_cnt), 8'd0);
        chk("s2_ncoins", 8'(coins_seen.size()), 8'd0);

        repeat (3) begin send(3'd1, 2'd3, 6'd0); wait_fin(); end
        chk("s3_sold_a", 8'(sold_out[0]), 8'(STK));
        send(3'd1, 2'd1, 6'd0); wait_fin();
        chk("s3_status", 8'(fin_status), STK ? 8'd2 : 8'd0);
        chk("s3_lat", 8'(fin_cyc - acc_cyc), STK ? 8'd2 : 8'd3);
        restock = 1'b1; restock_item = 3'd1; cyc(1);
        restock_item = 3'd6; cyc(1);
        restock = 1'b0;
        chk("s3_restock_sold", 8'(sold_out), 8'd0);
        if (STK) chk("s3_stockA", 8'(stock[0]), 8'd15);

        clr(); send(3'd3, 2'd1, 6'd7); wait_fin();
        chk("s4_status_chg", 8'(fin_status), 8'd3);
        chk("s4_nopay", 8'(coins_seen.size() + vack_cnt), 8'd0);
        clr(); send(3'd3, 2'd1, 6'd0); wait_fin();
        chk("s4_lat", 8'(fin_cyc - acc_cyc), 8'd3);
        chk("s4_status_ok", 8'(fin_status), 8'd0);
        chk("s4_vacks", 8'(vack_cnt), 8'd1);
        chk("s4_ncoins", 8'(coins_seen.size()), 8'd0);

        cack_auto = 1'b0;
        send(3'd4, 2'd1, 6'd10); wait_coin(3'b010);
        cyc(2);
        rst = 1'b1;
        #1;
        chk("s5_coin", 8'(coin_out), 8'd0);
        chk("s5_ready", 8'(req_ready), 8'd1);
        chk("s5_busy", 8'(busy), 8'd0);
        chk("s5_vreq", 8'(vend_req), 8'd0);
        f0 = fin_cnt;
        cyc(2);
        rst = 1'b0; cack_auto = 1'b1;
        cyc(4);
        chk("s5_nofin", 8'(fin_cnt - f0), 8'd0);

        clr(); cack_auto = 1'b0;
        send(3'd5, 2'd1, 6'd15); wait_coin(3'b010);
        req_valid = 1'b1; req_item = 3'd1; req_amt = 2'd1; req_change = 6'd0;
        cyc(1);
        req_valid = 1'b0; cack_m = 1'b1;
        cyc(1);
        cack_m = 1'b0;
        cyc(1);
        cack_auto = 1'b1;
        wait_fin();
        chk("s6_ncoins", 8'(coins_seen.size()), 8'd2);
        if (coins_seen.size() == 2) chk("s6_coin1", 8'(coins_seen[1]), 8'b001);
        cyc(3);
        chk("s6_idle", 8'({busy, req_ready}), 8'b01);

        vack_auto = 1'b0;
        send(3'd5, 2'd1, 6'd0); wait_vreq();
        cack_m = 1'b1; cyc(1);
        cack_m = 1'b0; vack_m = 1'b1; restock = 1'b1; restock_item = 3'd5; cyc(1);
        vack_m = 1'b0; restock = 1'b0; vack_auto = 1'b1;
        wait_fin();
        if (STK) chk("s7_stockE", 8'(stock[4]), 8'd15);
        repeat (5) begin send(3'd5, 2'd3, 6'd0); wait_fin(); end
        chk("s7_sold_e", 8'(sold_out[4]), 8'(STK));
        chk("s7_status", 8'(fin_status), 8'd0);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/vm_dispense_ctrl.md
VM_DISPENSE_CTRL -- requirements
Module: vm_dispense_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  system clock
- rst  in  1  async active-high reset
- req_valid  in  1  purchase result valid (from vending FSM done)
- req_item  in  3  item code; 1..5 = A..E
- req_amt  in  2  units to dispense, 1..3
- req_change  in  6  change owed, in cents
- req_ready  out  1  controller can accept a request
- vend_req  out  1  item motor request, held until acknowledged
- vend_item  out  3  item code for the motor
- vend_ack  in  1  motor completed one unit
- coin_out  out  3  one-hot payout coin, held until acknowledged: 001 nickel, 010 dime, 100 quarter
- coin_ack  in  1  hopper released coin_out
- fin_valid  out  1  one-cycle completion pulse
- fin_status  out  2  00 ok, 01 bad item/amt, 10 sold out, 11 bad change
- busy  out  1  FSM not in IDLE
- sold_out  out  5  bit i-1 high when stock of item i is 0
- restock  in  1  restock strobe
- restock_item  in  3  item code to refill

Function
REQ-003 The FSM SHALL have the states IDLE, CHECK, VEND, PAY and FIN.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready, and req_item/amt/change SHALL be captured into internal registers on that edge.
REQ-005 IDLE SHALL go to CHECK on accept and SHALL otherwise stay in IDLE; req_valid outside IDLE SHALL be ignored.
REQ-006 CHECK SHALL last exactly 1 cycle and SHALL test, in priority order:
- item not in 1..5 or amt==0 -> status 01
- stock<amt -> status 10
- change%5!=0 -> status 11
- otherwise -> ok
Any failure SHALL go to FIN with no vend and no payout; ok SHALL go to VEND.
REQ-007 VEND SHALL hold vend_req=1 with vend_item equal to the captured item. Each cycle with vend_ack=1 SHALL decrement remaining units by 1 and the item's stock by 1. When remaining units reach 0, the FSM SHALL go to PAY if change!=0, else to FIN.
REQ-008 After a vend_ack that leaves units remaining, vend_req SHALL stay high; one ack equals one unit.
REQ-009 PAY SHALL select the coin greedily from the remaining cents: >=25 quarter, else >=10 dime, else nickel. It SHALL hold coin_out one-hot until coin_ack, then subtract the coin value and re-select on the next cycle. On remaining==0 it SHALL go to FIN.
REQ-010 coin_out SHALL be 000 outside PAY; vend_req SHALL be 0 outside VEND.
REQ-011 FIN SHALL assert fin_valid=1 for exactly 1 cycle with fin_status, then return to IDLE. fin_status SHALL hold its value until the next FIN.
REQ-012 The minimum latency from accept to fin_valid SHALL be 2 cycles (reject path). For ok requests it SHALL be 2 + amt + coins cycles when acks are returned combinationally in the same cycle.
REQ-013 An ack arriving outside its matching state SHALL be ignored.
REQ-014 Arithmetic: units SHALL be 2-bit and change 6-bit; a subtraction SHALL never underflow, because the coin is selected so that coin value <= remaining.
REQ-015 Stock SHALL be five 4-bit counters. restock with a valid item SHALL set that counter to 15 in any state, and restock SHALL win over a same-cycle decrement of the same item. restock with an invalid item SHALL be ignored.
REQ-016 A counter at 0 SHALL never decrement, i.e. no wrap-around; CHECK guarantees this.
REQ-017 sold_out SHALL be combinational from the counters.

Reset
REQ-018 rst SHALL take effect immediately, including in the middle of a VEND or PAY sequence; in-flight work SHALL be discarded with no fin_valid.
REQ-019 Reset values SHALL be:
- FSM = IDLE, req_ready=1, busy=0
- vend_req=0, vend_item=0, coin_out=000
- fin_valid=0, fin_status=00
- all stock counters = 9, so sold_out=00000

Configuration
REQ-020 The macro VM_STOCK_TRACK_EN SHALL control stock tracking.
- Defined: stock counters, restock and the sold-out check SHALL be present as specified.
- Undefined: there SHALL be no counters, sold_out SHALL be tied to 00000, restock/restock_item SHALL be ignored, and status 10 SHALL never occur.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Item 2 (B), amt 2, change 40, acks immediate -> 2 vend_req/ack cycles, then coins quarter, dime, nickel; fin_status 00; B stock 9->7.
- Item 7, amt 1 -> fin_valid 2 cycles after accept, status 01; no vend_req, coin_out stays 000.
- Item 1 (A) bought 3+3+3, then amt 1 -> 4th request status 10 and sold_out[0]=1; restock item 1 -> stock 15, sold_out[0]=0 (with macro).
- Change 7 -> status 11, no payout; change 0 with amt 1 -> VEND then FIN, no PAY.
- rst asserted while coin_out=010 is held -> coin_out=000, FSM IDLE and req_ready=1 in the same cycle; no fin_valid.
- req_valid pulsed during PAY -> ignored; restock of the vending item on the same cycle as vend_ack -> counter = 15.
